mnist_argmax_collector: RTL and testbench
=========================================

Name: mnist_argmax_collector

Overview:
- Downstream consumer of the DSDMNIST output-buffer write stream (WE/ADDR/DATA, ten FP32 class scores per image).
- Snoops each write, tracks the running maximum score per image and emits one classification result (image index, winning class, winning score) per image.
- Results go through a small FIFO to a ready/valid consumer, such as a result RAM, UART formatter or LED display.
- Asserts done once IMGNUM results have been produced.

Parameters:
- IMGNUM, 10, images per run.
- FPW, 32, score width; IEEE-754 single precision, fixed at 32.
- OAW, $clog2(IMGNUM*10), score write address width.
- IW, max(1,$clog2(IMGNUM)), image index width.
- FDEPTH, 4, result FIFO depth; power of two, ≥2.

Ports:
- i_CLK  in  1  clock.
- i_RST  in  1  reset; synchronous, active-high.
- i_START  in  1  rising edge arms a new run.
- i_OUTBUF_WE  in  1  score write strobe from the accelerator.
- i_OUTBUF_ADDR  in  OAW  score address = img*10 + class.
- i_OUTBUF_DATA  in  FPW  FP32 score.
- o_RES_VALID  out  1  FIFO head valid.
- i_RES_READY  in  1  consumer accepts the head when high together with valid.
- o_RES_IMG  out  IW  image index of the head entry.
- o_RES_CLASS  out  4  argmax class 0..9.
- o_RES_SCORE  out  FPW  winning score.
- o_DONE  out  1  level; all IMGNUM results produced and the FIFO drained.
- o_ERR  out  2  sticky error flags: bit0 address sequence error, bit1 FIFO overflow.

Behaviour:
Reset:
- While i_RST is high, all outputs are 0, the FSM is in IDLE and the FIFO is empty.

FSM:
- States are IDLE, COLLECT, FLUSH and DONE.
- IDLE → COLLECT on an i_START rising edge (registered edge detect). The transition clears the class counter (0..9), the image counter, the running max, o_ERR and the FIFO.
- COLLECT: each i_OUTBUF_WE advances the class counter.
  - The expected address is held in a running counter; the block does not divide the address.
  - If the address differs from the expected value, set o_ERR[0]. The score is still used at the counter's position.
- Compare rule: map each FP32 value to an ordered key. Positive values (sign 0) get the MSB set; negative values are bitwise inverted. Compare keys unsigned.
  - Class 0 loads unconditionally.
  - A later class replaces the max only on strictly greater, so on ties the lower index wins.
  - +0 and -0 compare equal (special case).
  - NaN (exp=0xFF, mant≠0) never replaces and never wins unless it is class 0 and all others are also NaN.
- On the write of class 9, the push happens in the next cycle with the final winner: {img, class, score} enters the FIFO at cycle N+1, so o_RES_VALID rises no earlier than N+2.
  - The class counter wraps to 0 and the image counter increments.
- After IMGNUM images, COLLECT → FLUSH.
- FLUSH → DONE when the FIFO is empty. In DONE, o_DONE=1 until the next i_START edge or reset.
- Writes are ignored outside COLLECT.
- An i_START edge in any non-IDLE state restarts the run (same as IDLE→COLLECT); any partial image is discarded.

FIFO:
- Standard ready/valid: the head is stable while o_RES_VALID && !i_RES_READY.
- Push and pop in the same cycle are allowed, including when full (no overflow).
- A push when full and not popping drops the new entry and sets o_ERR[1].
- Pointers are IW-free binary and wrap modulo FDEPTH.

Decomposition:
- Package mnist_pkg: NUM_CLASSES=10, fp32_key() function, fp32_is_nan() function, the res_t struct {img, class, score}.
- One sub-module, mnist_res_fifo: parameterised sync FIFO with ready/valid on the pop side, push/full on the push side and an overflow pulse.

Test Plan:
1. Scores for image 0 = {1.0,2.0,5.0,3.0,0,0,0,0,0,-1.0}, consumer always ready → one result img=0, class=2, score=0x40A00000, o_ERR=0.
2. Ten images with argmax = img index, then the full run → results img 0..9 with class=img in order; o_DONE rises after the last pop.
3. Image with ties: 4.0 at class 3 and class 7 → class=3. Image with all -0.0 and class 0 = +0.0 → class=0.
4. i_RES_READY held low for 6 images → first FDEPTH=4 entries retained, o_ERR[1]=1. Releasing ready pops images 0..3 unchanged.
5. A write with ADDR skipping from 12 to 14 → o_ERR[0]=1, and the image 1 result is still emitted after 10 writes.
6. i_START re-pulse mid-image 3, then a clean run → counters restart at img 0, no stale result from image 3, o_ERR cleared. i_RST asserted in COLLECT → all outputs 0 the next cycle.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared types and FP32 ordering helpers for the MNIST argmax result collector.
package mnist_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int IMG_FIELD_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_FLUSH,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [IMG_FIELD_W-1:0] img;
    logic [3:0]             cls;
    logic [31:0]            score;
  } res_t;

  // Monotonic unsigned key for FP32; both zeros share one key so they tie.
  function automatic logic [31:0] fp32_key(input logic [31:0] v);
    if (v[30:0] == 31'd0) return 32'h8000_0000;
    return v[31] ? ~v : (v | 32'h8000_0000);
  endfunction

  function automatic logic fp32_is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/mnist_res_fifo.sv
// Synchronous result FIFO: push side with overflow pulse, ready/valid pop side.
module mnist_res_fifo #(
  parameter int W     = 52,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data,
  output logic         ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign pop_valid = (count != '0);
  assign do_pop    = pop_valid && pop_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push   = push && (!full || do_pop);
  assign ovf       = push && full && !do_pop;
  assign pop_data  = pop_valid ? mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; the empty gating on pop_data
  // keeps unwritten words from ever reaching the outputs.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mnist_argmax_collector.sv
// Snoops the accelerator score-write stream and emits one argmax result per image.
module mnist_argmax_collector
  import mnist_pkg::*;
#(
  parameter int IMGNUM = 10,
  parameter int FPW    = 32,
  parameter int OAW    = $clog2(IMGNUM*10),
  parameter int IW     = (IMGNUM > 1) ? $clog2(IMGNUM) : 1,
  parameter int FDEPTH = 4
) (
  input  logic           i_CLK,
  input  logic           i_RST,
  input  logic           i_START,
  input  logic           i_OUTBUF_WE,
  input  logic [OAW-1:0] i_OUTBUF_ADDR,
  input  logic [FPW-1:0] i_OUTBUF_DATA,
  output logic           o_RES_VALID,
  input  logic           i_RES_READY,
  output logic [IW-1:0]  o_RES_IMG,
  output logic [3:0]     o_RES_CLASS,
  output logic [FPW-1:0] o_RES_SCORE,
  output logic           o_DONE,
  output logic [1:0]     o_ERR
);

  localparam logic [3:0]    LAST_CLASS = 4'(NUM_CLASSES - 1);
  localparam logic [IW-1:0] LAST_IMG   = IW'(IMGNUM - 1);

  state_t         state;
  logic           start_q;
  logic           start_edge;
  logic [3:0]     cls_cnt;
  logic [IW-1:0]  img_cnt;
  logic [OAW-1:0] exp_addr;
  logic [FPW-1:0] max_score;
  logic [3:0]     max_cls;
  logic           push_pend;
  logic [IW-1:0]  pend_img;
  logic           replace;
  logic           fifo_valid;
  logic           fifo_ovf;
  res_t           push_res;
  res_t           head;

  assign start_edge = i_START && !start_q;

  always_comb begin
    // NOTE: a default on entry gives every path a value, so no latch is inferred.
    replace = 1'b0;
    if (cls_cnt == '0)
      replace = 1'b1;
    else if (!fp32_is_nan(i_OUTBUF_DATA))
      replace = fp32_is_nan(max_score) || (fp32_key(i_OUTBUF_DATA) > fp32_key(max_score));
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      cls_cnt   <= '0;
      img_cnt   <= '0;
      exp_addr  <= '0;
      max_score <= '0;
      max_cls   <= '0;
      push_pend <= 1'b0;
      pend_img  <= '0;
      o_ERR     <= '0;
    end else begin
      start_q   <= i_START;
      push_pend <= 1'b0;
      if (start_edge) begin
        state     <= S_COLLECT;
        cls_cnt   <= '0;
        img_cnt   <= '0;
        exp_addr  <= '0;
        max_score <= '0;
        max_cls   <= '0;
        o_ERR     <= '0;
      end else begin
        if (fifo_ovf) o_ERR[1] <= 1'b1;
        case (state)
          S_COLLECT: begin
            if (i_OUTBUF_WE) begin
              if (i_OUTBUF_ADDR != exp_addr) o_ERR[0] <= 1'b1;
              exp_addr <= exp_addr + 1'b1;
              if (replace) begin
                max_score <= i_OUTBUF_DATA;
                max_cls   <= cls_cnt;
              end
              if (cls_cnt == LAST_CLASS) begin
                // The winner settles at this edge; it is pushed one cycle later.
                cls_cnt   <= '0;
                push_pend <= 1'b1;
                pend_img  <= img_cnt;
                if (img_cnt == LAST_IMG) state <= S_FLUSH;
                else                     img_cnt <= img_cnt + 1'b1;
              end else begin
                cls_cnt <= cls_cnt + 1'b1;
              end
            end
          end
          S_FLUSH: if (!fifo_valid && !push_pend) state <= S_DONE;
          default: ;
        endcase
      end
    end
  end

  assign push_res = '{img: IMG_FIELD_W'(pend_img), cls: max_cls, score: 32'(max_score)};

  mnist_res_fifo #(
    .W     ($bits(res_t)),
    .DEPTH (FDEPTH)
  ) u_fifo (
    .clk       (i_CLK),
    .rst       (i_RST),
    .clr       (start_edge),
    .push      (push_pend),
    .push_data (push_res),
    .pop_valid (fifo_valid),
    .pop_ready (i_RES_READY),
    .pop_data  (head),
    .ovf       (fifo_ovf)
  );

  assign o_RES_VALID = fifo_valid;
  assign o_RES_IMG   = IW'(head.img);
  assign o_RES_CLASS = head.cls;
  assign o_RES_SCORE = FPW'(head.score);
  assign o_DONE      = (state == S_DONE);

endmodule

// File: tb/tb_mnist_argmax_collector.sv
// Randomised scoreboard bench for mnist_argmax_collector against a real-valued argmax model.
module tb_mnist_argmax_collector;

  localparam int OAW = 7;
  localparam int IW  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           we;
  logic [OAW-1:0] addr;
  logic [31:0]    data;
  logic           res_valid;
  logic           res_ready;
  logic [IW-1:0]  res_img;
  logic [3:0]     res_class;
  logic [31:0]    res_score;
  logic           done;
  logic [1:0]     err;

  typedef struct {
    int          img;
    int          cls;
    logic [31:0] score;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   ready_mode = 1;   // 0: held low, 1: held high, 2: random

  mnist_argmax_collector dut (
    .i_CLK         (clk),
    .i_RST         (rst),
    .i_START       (start),
    .i_OUTBUF_WE   (we),
    .i_OUTBUF_ADDR (addr),
    .i_OUTBUF_DATA (data),
    .o_RES_VALID   (res_valid),
    .i_RES_READY   (res_ready),
    .o_RES_IMG     (res_img),
    .o_RES_CLASS   (res_class),
    .o_RES_SCORE   (res_score),
    .o_DONE        (done),
    .o_ERR         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: decode each score to its real value and take the first maximum.
  function automatic bit ref_is_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 0);
  endfunction

  function automatic real fp_val(input logic [31:0] b);
    int  e = int'(b[30:23]);
    real m = real'(b[22:0]) / 8388608.0;
    real v;
    if (e == 255)    v = 1.0e300;
    else if (e == 0) v = m * (2.0 ** (-126));
    else             v = (1.0 + m) * (2.0 ** (e - 127));
    return b[31] ? -v : v;
  endfunction

  function automatic int ref_argmax(input logic [31:0] s[10]);
    int w = 0;
    for (int c = 1; c < 10; c++)
      if (!ref_is_nan(s[c]) && (ref_is_nan(s[w]) || fp_val(s[c]) > fp_val(s[w]))) w = c;
    return w;
  endfunction

  function automatic logic [31:0] rand_score(input bit special);
    logic [31:0] r = $urandom;
    if (!special) return {r[31], 1'b0, r[29:0]};
    case ($urandom_range(0, 11))
      0:       return {r[31], 8'hFF, 1'b1, r[21:0]};
      1:       return 32'h7F80_0000;
      2:       return 32'hFF80_0000;
      3:       return {r[31], 31'd0};
      default: return r;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       res_ready = 1'b0;
      1:       res_ready = 1'b1;
      default: res_ready = ($urandom_range(0, 9) < 7);
    endcase
  end

  // Monitor: every accepted head is compared with the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", {60'd0, res_img}, 64'hFFFF);
      end else begin
        e = sb.pop_front();
        check("res_img", res_img, e.img);
        check("res_class", res_class, e.cls);
        check("res_score", res_score, e.score);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_run();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
  endtask

  task automatic send_image(input int img, input logic [31:0] s[10], input bit expect_res,
                            input int skip_cls, input int n_writes);
    if (expect_res && n_writes == 10) begin
      exp_t e;
      e.img   = img;
      e.cls   = ref_argmax(s);
      e.score = s[e.cls];
      sb.push_back(e);
    end
    for (int c = 0; c < n_writes; c++) begin
      int a;
      a    = img * 10 + c + ((skip_cls >= 0 && c >= skip_cls) ? 1 : 0);
      we   = 1'b1;
      addr = a[OAW-1:0];
      data = s[c];
      tick(1);
      we = 1'b0;
      tick($urandom_range(0, 1));
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 400) begin tick(1); n++; end
    check(name, done, 1);
    check({name, "_drained"}, sb.size(), 0);
  endtask

  initial begin
    logic [31:0] s[10];

    rst = 1'b1; start = 1'b0; we = 1'b0; addr = '0; data = '0;
    tick(3);
    check("rst_valid", res_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_score", res_score, 0);
    rst = 1'b0;
    tick(2);

    // Run A: known image, address skip, ties, signed zeros, random specials.
    ready_mode = 1;
    start_run();
    s = '{32'h3F80_0000, 32'h4000_0000, 32'h40A0_0000, 32'h4040_0000, 0, 0, 0, 0, 0, 32'hBF80_0000};
    send_image(0, s, 1, -1, 10);
    tick(4);
    check("img0_err", err, 0);
    check("img0_popped", sb.size(), 0);
    for (int c = 0; c < 10; c++) s[c] = rand_score(0);
    send_image(1, s, 1, 3, 10);
    for (int c = 0; c < 10; c++) s[c] = rand_score(0);
    s[3] = 32'h4080_0000;
    s[7] = 32'h4080_0000;
    send_image(2, s, 1, -1, 10);
    for (int c = 0; c < 10; c++) s[c] = 32'h8000_0000;
    s[0] = 32'h0000_0000;
    send_image(3, s, 1, -1, 10);
    for (int i = 4; i < 10; i++) begin
      for (int c = 0; c < 10; c++) s[c] = rand_score(1);
      send_image(i, s, 1, -1, 10);
    end
    wait_done("runA_done");
    check("runA_err", err, 2'b01);

    // Run B: argmax equals the image index, consumer randomly stalls.
    ready_mode = 2;
    start_run();
    check("runB_done_cleared", done, 0);
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 10; c++) s[c] = rand_score(0);
      s[i] = 32'h4F00_0000 | 32'($urandom_range(0, 255));
      send_image(i, s, 1, -1, 10);
    end
    wait_done("runB_done");
    check("runB_err", err, 0);

    // Run C: stalled consumer overflows the FIFO; the first entries survive.
    ready_mode = 0;
    tick(2);
    start_run();
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 10; c++) s[c] = rand_score(1);
      send_image(i, s, i < 4, -1, 10);
    end
    tick(3);
    check("ovf_err", err, 2'b10);
    check("ovf_head_valid", res_valid, 1);
    check("ovf_head_img", res_img, 0);
    check("ovf_no_done", done, 0);
    ready_mode = 1;
    tick(8);
    check("ovf_drained", sb.size(), 0);
    for (int i = 6; i < 10; i++) begin
      for (int c = 0; c < 10; c++) s[c] = rand_score(1);
      send_image(i, s, 1, -1, 10);
    end
    wait_done("runC_done");
    check("runC_err", err, 2'b10);

    // Run D: restart mid-image 3 drops the partial image and clears errors.
    start_run();
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 10; c++) s[c] = rand_score(1);
      send_image(i, s, 1, (i == 0) ? 5 : -1, 10);
    end
    for (int c = 0; c < 10; c++) s[c] = rand_score(1);
    send_image(3, s, 0, -1, 4);
    tick(3);
    check("pre_restart_err", err, 2'b01);
    start_run();
    check("restart_err_clr", err, 0);
    check("restart_no_stale", res_valid, 0);
    ready_mode = 2;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 10; c++) s[c] = rand_score(1);
      send_image(i, s, 1, -1, 10);
    end
    wait_done("runD_done");
    check("runD_err", err, 0);

    // Reset during COLLECT with a result waiting in the FIFO.
    ready_mode = 0;
    tick(2);
    start_run();
    for (int c = 0; c < 10; c++) s[c] = rand_score(0);
    send_image(0, s, 1, -1, 10);
    send_image(1, s, 0, -1, 3);
    tick(2);
    check("pre_rst_valid", res_valid, 1);
    rst = 1'b1;
    sb.delete();
    tick(1);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_img", res_img, 0);
    check("mid_rst_class", res_class, 0);
    check("mid_rst_score", res_score, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    rst = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
